// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC priority select, EPC capture, and an
// optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             PCReSet,
    input  logic             isPCWrite,
    input  logic             isException,
    input  logic             isBranch,
    input  logic [WIDTH-1:0] branchTarget,
    input  logic             isJump,
    input  logic [WIDTH-1:0] jumpTarget,
    input  logic             isCall,
    input  logic             isReturn,
    input  logic [WIDTH-1:0] rasPushData,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] EPC,
    output logic             redirected,
    output logic [WIDTH-1:0] rasTop,
    output logic             rasValid
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_EXC,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_SEQ,
        SRC_HOLD
    } pc_src_e;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_redir;
    pc_src_e          w_src;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_pc_plus4;
    logic             w_is_redirect;

    assign w_pc_plus4 = r_pc + WIDTH'(4);

    always_comb begin
        w_src = SRC_HOLD;
        priority case (1'b1)
            PCReSet:     w_src = SRC_RESET;
            isException: w_src = SRC_EXC;
            isBranch:    w_src = SRC_BRANCH;
            isJump:      w_src = SRC_JUMP;
            isPCWrite:   w_src = SRC_SEQ;
            default:     w_src = SRC_HOLD;
        endcase
    end

    always_comb begin
        w_next_pc = r_pc;
        case (w_src)
            SRC_RESET:  w_next_pc = RESET_VECTOR;
            SRC_EXC:    w_next_pc = EXC_VECTOR;
            SRC_BRANCH: w_next_pc = branchTarget & ALIGN_MASK;
            SRC_JUMP:   w_next_pc = jumpTarget & ALIGN_MASK;
            SRC_SEQ:    w_next_pc = w_pc_plus4;
            default:    w_next_pc = r_pc;
        endcase
    end

    assign w_is_redirect = (w_src == SRC_EXC) ||
                           (w_src == SRC_BRANCH) ||
                           (w_src == SRC_JUMP);

    always_ff @(posedge clk) begin
        if (PCReSet) begin
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_redir <= 1'b0;
        end else begin
            r_pc    <= w_next_pc;
            r_redir <= w_is_redirect;
            if (isException)
                r_epc <= r_pc;
        end
    end

    assign PC         = r_pc;
    assign PCPlus4    = w_pc_plus4;
    assign EPC        = r_epc;
    assign redirected = r_redir;

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]    r_sp;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    w_sp_inc;
    logic             w_ras_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_repl;

    // Push/pop are suppressed while the pipeline is being reset or flushed.
    assign w_ras_ok = !PCReSet && !isException;
    assign w_sp_inc = r_sp + PW'(1);
    assign w_push   = w_ras_ok && isCall && !isReturn;
    assign w_pop    = w_ras_ok && isReturn && !isCall && (r_cnt != '0);
    assign w_repl   = w_ras_ok && isCall && isReturn;

    always_ff @(posedge clk) begin
        if (PCReSet) begin
            r_sp  <= '0;
            r_cnt <= '0;
        end else if (isException) begin
            r_cnt <= '0;
        end else if (w_push) begin
            r_sp <= w_sp_inc;
            if (r_cnt != FULL)
                r_cnt <= r_cnt + CW'(1);
        end else if (w_pop) begin
            r_sp  <= r_sp - PW'(1);
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // A full stack simply wraps, overwriting the oldest entry.
    always_ff @(posedge clk) begin
        if (w_push)
            r_stack[w_sp_inc] <= rasPushData;
        else if (w_repl)
            r_stack[r_sp] <= rasPushData;
    end

    assign rasTop   = r_stack[r_sp];
    assign rasValid = (r_cnt != '0);
`else
    logic w_unused_ras;

    assign w_unused_ras = ^{isCall, isReturn, rasPushData};
    assign rasTop       = '0;
    assign rasValid     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against a queue-based reference model.
module tb_pc_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0;
    logic        exc = 1'b0;
    logic        br = 1'b0;
    logic [31:0] bt = '0;
    logic        jmp = 1'b0;
    logic [31:0] jt = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pd = '0;
    logic [31:0] pc, pc4, epc, top;
    logic        redir, valid;

    logic       rst8 = 1'b0;
    logic       wr8 = 1'b0;
    logic [7:0] pc8, pc4_8, epc8, unused_top8;
    logic       redir8, valid8;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_redir;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk(clk), .PCReSet(rst), .isPCWrite(wr), .isException(exc),
        .isBranch(br), .branchTarget(bt), .isJump(jmp), .jumpTarget(jt),
        .isCall(call), .isReturn(ret), .rasPushData(pd),
        .PC(pc), .PCPlus4(pc4), .EPC(epc), .redirected(redir),
        .rasTop(top), .rasValid(valid)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hFC), .EXC_VECTOR(8'h80)) u_dut8 (
        .clk(clk), .PCReSet(rst8), .isPCWrite(wr8), .isException(1'b0),
        .isBranch(1'b0), .branchTarget(8'h00), .isJump(1'b0),
        .jumpTarget(8'h00), .isCall(1'b0), .isReturn(1'b0),
        .rasPushData(8'h00), .PC(pc8), .PCPlus4(pc4_8), .EPC(epc8),
        .redirected(redir8), .rasTop(unused_top8), .rasValid(valid8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic i_rst, i_wr, i_exc, i_br,
                         input logic [31:0] i_bt, input logic i_jmp,
                         input logic [31:0] i_jt, input logic i_call,
                         input logic i_ret, input logic [31:0] i_pd);
        if (i_rst) begin
            m_pc = 32'h3000; m_epc = 0; m_redir = 0; m_ras.delete();
        end else if (i_exc) begin
            m_epc = m_pc; m_pc = 32'h4180; m_redir = 1; m_ras.delete();
        end else begin
            m_redir = i_br | i_jmp;
            if (i_br) m_pc = {i_bt[31:2], 2'b00};
            else if (i_jmp) m_pc = {i_jt[31:2], 2'b00};
            else if (i_wr) m_pc = m_pc + 4;
`ifdef PC_RAS_EN
            if (i_call && i_ret) begin
                if (m_ras.size() > 0) m_ras[m_ras.size()-1] = i_pd;
            end else if (i_call) begin
                m_ras.push_back(i_pd);
                if (m_ras.size() > D) void'(m_ras.pop_front());
            end else if (i_ret) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end
`endif
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("pc4", pc4, m_pc + 32'd4);
        check("epc", epc, m_epc);
        check("redir", {31'b0, redir}, {31'b0, m_redir});
`ifdef PC_RAS_EN
        check("ras_valid", {31'b0, valid}, {31'b0, m_ras.size() != 0});
        if (m_ras.size() > 0)
            check("ras_top", top, m_ras[m_ras.size()-1]);
`else
        check("ras_valid", {31'b0, valid}, 32'd0);
        check("ras_top", top, 32'd0);
`endif
    endtask

    task automatic step(input logic i_rst, i_wr, i_exc, i_br,
                        input logic [31:0] i_bt, input logic i_jmp,
                        input logic [31:0] i_jt, input logic i_call,
                        input logic i_ret, input logic [31:0] i_pd);
        rst = i_rst; wr = i_wr; exc = i_exc; br = i_br; bt = i_bt;
        jmp = i_jmp; jt = i_jt; call = i_call; ret = i_ret; pd = i_pd;
        @(posedge clk);
        model(i_rst, i_wr, i_exc, i_br, i_bt, i_jmp, i_jt, i_call,
              i_ret, i_pd);
        #1;
        compare_all();
    endtask

    initial begin
        rst8 = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", pc, 32'h3000);
        check("w8_reset_pc", {24'b0, pc8}, 32'hFC);
        check("w8_pc4", {24'b0, pc4_8}, 32'h00);
        check("w8_epc", {24'b0, epc8}, 32'h00);
        check("w8_redir", {31'b0, redir8}, 32'd0);
        check("w8_valid", {31'b0, valid8}, 32'd0);
        rst8 = 1'b0; wr8 = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        wr8 = 1'b0;
        check("w8_wrap", {24'b0, pc8}, 32'h08);
        check("seq_pc", pc, 32'h300C);
        check("seq_pc4", pc4, 32'h3010);
        check("seq_redir", {31'b0, redir}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stall_pc", pc, 32'h3010);
        step(0, 0, 0, 1, 32'h3103, 0, 0, 0, 0, 0);
        check("br_pc", pc, 32'h3100);
        check("br_redir", {31'b0, redir}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("br_redir_drop", {31'b0, redir}, 32'd0);
        step(0, 1, 0, 0, 0, 1, 32'h3020, 0, 0, 0);
        step(0, 1, 1, 1, 32'h5000, 1, 32'h6000, 1, 0, 32'h77);
        check("exc_pc", pc, 32'h4180);
        check("exc_epc", epc, 32'h3020);
        check("exc_ras", {31'b0, valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_exc_pc", pc, 32'h4184);
        check("post_exc_epc", epc, 32'h3020);
`ifdef PC_RAS_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'(i * 16));
        check("ras_full_top", top, 32'h50);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("ras_pop1", top, 32'h40);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("ras_pop2", top, 32'h30);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("ras_pop3", top, 32'h20);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("ras_pop4_empty", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("ras_pop5_empty", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hB0);
        check("ras_repl_top", top, 32'hB0);
        check("ras_repl_valid", {31'b0, valid}, 32'd1);
        step(1, 1, 0, 1, 32'h9000, 0, 0, 1, 0, 32'hC0);
        check("ras_reset_valid", {31'b0, valid}, 32'd0);
        check("ras_reset_pc", pc, 32'h3000);
`endif
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 5) == 0), $urandom,
                 ($urandom_range(0, 5) == 0), $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), $urandom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program-counter unit for the pipelined MIPS core, the successor to the plain PC register. It holds the fetch PC, produces PC+4 and selects the next PC from reset, exception, branch, jump, stall and sequential sources by fixed priority. It also captures the exception PC and, optionally, keeps a small return-address stack for `jal`/`jr $ra` prediction. The block sits between the hazard unit, the branch/jump resolution logic in the datapath, and instruction memory.

## Interface
- WIDTH, 32: PC width in bits (≥ 8).
- RESET_VECTOR, 32'h0000_3000: PC value after reset.
- EXC_VECTOR, 32'h0000_4180: PC value loaded on exception.
- RAS_DEPTH, 4: return-address stack entries, a power of 2 (used only with PC_RAS_EN).

- clk  in  1  single clock; all state updates on its rising edge.
- PCReSet  in  1  synchronous, active-high reset.
- isPCWrite  in  1  1 = advance sequentially; 0 = stall (hold PC).
- isException  in  1  take exception this cycle.
- isBranch  in  1  taken branch redirect.
- branchTarget  in  WIDTH  branch destination.
- isJump  in  1  jump redirect (j/jal/jr).
- jumpTarget  in  WIDTH  jump destination.
- isCall  in  1  push rasPushData (PC_RAS_EN only).
- isReturn  in  1  pop (PC_RAS_EN only).
- rasPushData  in  WIDTH  return address to push.
- PC  out  WIDTH  current fetch PC (registered).
- PCPlus4  out  WIDTH  PC + 4 (combinational).
- EPC  out  WIDTH  PC captured on exception (registered).
- redirected  out  1  registered; high for one cycle after any non-sequential load (exception, branch, jump).
- rasTop  out  WIDTH  top-of-stack value (0 when PC_RAS_EN undefined).
- rasValid  out  1  stack non-empty (0 when PC_RAS_EN undefined).

## Operation
- Next-PC priority, evaluated every cycle: PCReSet > isException > isBranch > isJump > isPCWrite > hold.
- Reset: PC = RESET_VECTOR, EPC = 0, redirected = 0, stack count = 0, stack pointer = 0.
- Exception: PC = EXC_VECTOR, EPC = current PC, stack cleared (count = 0), redirected = 1.
- Branch/jump: PC = target with bits [1:0] forced to 00, redirected = 1. Redirects are taken even when isPCWrite = 0; a redirect overrides a stall.
- Sequential: PC = PC + 4 modulo 2^WIDTH. PC at all-ones-aligned wraps to 0 with no flag.
- Hold: PC, EPC unchanged; redirected = 0.
- EPC changes only on exception or reset.

## Timing
- Single-cycle latency: inputs sampled at edge N are reflected on PC after edge N.
- PCPlus4 is combinational from PC, zero latency.
- redirected asserts in the cycle following the load and lasts exactly one cycle. Back-to-back redirects keep it high continuously.
- Simultaneous isBranch and isJump: branch wins. Either of them together with isException: exception wins, and the redirect is dropped.
- Reset asserted mid-stall or mid-redirect: reset values load on that edge regardless of other inputs.

## Configuration
- PC_RAS_EN defined: a circular stack of RAS_DEPTH entries of WIDTH bits, with pointer and count registers.
  - isCall pushes rasPushData. When full, the oldest entry is overwritten and count saturates at RAS_DEPTH.
  - isReturn pops. When empty, the pop does nothing and count stays 0.
  - isCall and isReturn together: the top entry is replaced and count is unchanged.
  - Push/pop happen only in cycles with no reset or exception.
  - rasTop = entry at top; rasValid = (count ≠ 0). Both are registered-state outputs.
  - Stack contents never drive PC directly; the datapath chooses whether to use rasTop as jumpTarget.
- PC_RAS_EN undefined: no stack storage; isCall/isReturn/rasPushData ignored; rasTop = 0, rasValid = 0.

## Test plan
- Reset then 3 cycles of isPCWrite = 1 → PC = 3000, 3004, 3008, 300C; PCPlus4 = 3010; redirected = 0.
- PC = 3010, isPCWrite = 0 for 2 cycles, then isBranch = 1 with branchTarget = 3103 while isPCWrite = 0 → PC holds 3010, then becomes 3100; redirected = 1 for one cycle.
- PC = 3020, isException = isBranch = isJump = 1 → PC = 4180, EPC = 3020; stack cleared; following cycle isPCWrite = 1 → PC = 4184, EPC still 3020.
- WIDTH = 8, RESET_VECTOR = 8'hFC, isPCWrite = 1 → PC = FC then 00 (wrap).
- PC_RAS_EN, RAS_DEPTH = 4: push 10, 20, 30, 40, 50 → rasTop = 50, count 4. Then 4 pops → rasTop 40, 30, 20, then rasValid = 0. A further pop leaves rasValid = 0.
- PC_RAS_EN: push A, then isCall = isReturn = 1 with B → rasTop = B, count 1. Assert PCReSet mid-sequence → rasValid = 0, PC = 3000.
